// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: data bus access, load/store lane alignment, ME/WB register
// Bus accesses hold the pipeline via stall_M until ack, or until a 16-cycle timeout drops the access.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] write_data_M,
  input  logic [4:0]  rd_M,
  input  logic [1:0]  wb_ctrl_M,
  input  logic        we_reg_M,
  input  logic        we_mem_M,
  input  logic [2:0]  ls_type_M,
  input  logic [31:0] PC_M,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        stall_M,
  output logic        misalign_M,
  output logic        bus_err_M,
  output logic [31:0] ALU_result_W,
  output logic [31:0] mem_data_W,
  output logic [4:0]  rd_W,
  output logic [1:0]  wb_ctrl_W,
  output logic        we_reg_W,
  output logic [31:0] PC_W
);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  size_t       size;
  logic        is_unsigned;
  logic        load;
  logic        store;
  logic        mem_op;
  logic        misaligned;
  logic        req_raw;
  logic        timeout;
  logic        bubble;
  logic [1:0]  addr_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  assign addr_lo = ALU_result_M[1:0];
  assign load    = (wb_ctrl_M == 2'b01) && we_reg_M;
  assign store   = we_mem_M;
  assign mem_op  = load || store;

  always_comb begin
    size        = SZ_WORD;
    is_unsigned = 1'b0;
    case (ls_type_M)
      3'b000: size = SZ_BYTE;
      3'b001: size = SZ_HALF;
      3'b100: begin size = SZ_BYTE; is_unsigned = 1'b1; end
      3'b101: begin size = SZ_HALF; is_unsigned = 1'b1; end
      default: size = SZ_WORD;
    endcase
  end

  assign misaligned = mem_op && (((size == SZ_HALF) && addr_lo[0]) ||
                                 ((size == SZ_WORD) && (addr_lo != 2'b00)));

  // Raw request ignores rst so the FSM sees it; external outputs are forced low during reset.
  assign req_raw = (state == WAIT) || ((state == IDLE) && mem_op && !misaligned);
  assign timeout = (state == WAIT) && !dbus_ack && (wait_cnt == 4'd15);

  assign dbus_req   = !rst && req_raw;
  assign dbus_we    = dbus_req && store;
  assign dbus_addr  = {ALU_result_M[31:2], 2'b00};
  assign stall_M    = dbus_req && !dbus_ack && !((state == WAIT) && (wait_cnt == 4'd15));
  assign misalign_M = !rst && misaligned;
  assign bus_err_M  = !rst && timeout;

  always_comb begin
    st_be   = 4'b1111;
    st_data = write_data_M;
    case (size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << addr_lo;
        st_data = {4{write_data_M[7:0]}};
      end
      SZ_HALF: begin
        st_be   = 4'b0011 << addr_lo;
        st_data = {2{write_data_M[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = write_data_M;
      end
    endcase
  end

  assign dbus_be    = store ? st_be : 4'b0000;
  assign dbus_wdata = st_data;

  always_comb begin
    ld_byte = dbus_rdata[7:0];
    case (addr_lo)
      2'd0: ld_byte = dbus_rdata[7:0];
      2'd1: ld_byte = dbus_rdata[15:8];
      2'd2: ld_byte = dbus_rdata[23:16];
      default: ld_byte = dbus_rdata[31:24];
    endcase
  end

  assign ld_half = addr_lo[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

  always_comb begin
    ld_data = dbus_rdata;
    case (size)
      SZ_BYTE: ld_data = is_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = is_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_raw && !dbus_ack) begin
            state    <= WAIT;
            wait_cnt <= 4'd0;
          end
        end
        WAIT: begin
          if (dbus_ack || (wait_cnt == 4'd15)) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stalled, timed-out and misaligned instructions all leave a bubble in W.
  assign bubble = stall_M || timeout || misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_result_W <= 32'd0;
      mem_data_W   <= 32'd0;
      rd_W         <= 5'd0;
      wb_ctrl_W    <= 2'd0;
      we_reg_W     <= 1'b0;
      PC_W         <= 32'd0;
    end else if (bubble) begin
      ALU_result_W <= 32'd0;
      mem_data_W   <= 32'd0;
      rd_W         <= 5'd0;
      wb_ctrl_W    <= 2'd0;
      we_reg_W     <= 1'b0;
      PC_W         <= 32'd0;
    end else begin
      ALU_result_W <= ALU_result_M;
      mem_data_W   <= load ? ld_data : 32'd0;
      rd_W         <= rd_M;
      wb_ctrl_W    <= wb_ctrl_M;
      we_reg_W     <= we_reg_M;
      PC_W         <= PC_M;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
// Driver pushes expected W records; a monitor pops one at every non-stalled edge.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] ALU_result_M;
  logic [31:0] write_data_M;
  logic [4:0]  rd_M;
  logic [1:0]  wb_ctrl_M;
  logic        we_reg_M;
  logic        we_mem_M;
  logic [2:0]  ls_type_M;
  logic [31:0] PC_M;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic        stall_M;
  logic        misalign_M;
  logic        bus_err_M;
  logic [31:0] ALU_result_W;
  logic [31:0] mem_data_W;
  logic [4:0]  rd_W;
  logic [1:0]  wb_ctrl_W;
  logic        we_reg_W;
  logic [31:0] PC_W;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic        we;
    logic [31:0] pc;
  } wrec_t;

  wrec_t q[$];
  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ALU_result_M(ALU_result_M), .write_data_M(write_data_M), .rd_M(rd_M),
    .wb_ctrl_M(wb_ctrl_M), .we_reg_M(we_reg_M), .we_mem_M(we_mem_M),
    .ls_type_M(ls_type_M), .PC_M(PC_M),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_rdata(dbus_rdata),
    .dbus_ack(dbus_ack), .stall_M(stall_M), .misalign_M(misalign_M),
    .bus_err_M(bus_err_M), .ALU_result_W(ALU_result_W), .mem_data_W(mem_data_W),
    .rd_W(rd_W), .wb_ctrl_W(wb_ctrl_W), .we_reg_W(we_reg_W), .PC_W(PC_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [1:0] wb, input logic wr, input logic wm,
                       input logic [2:0] ls, input logic [31:0] pc);
    ALU_result_M = addr; write_data_M = wdata; rd_M = rd; wb_ctrl_M = wb;
    we_reg_M = wr; we_mem_M = wm; ls_type_M = ls; PC_M = pc;
  endtask

  task automatic check_w_zero(input string nm);
    chk({nm, ".alu_w"}, ALU_result_W, 32'd0);
    chk({nm, ".mem_w"}, mem_data_W, 32'd0);
    chk({nm, ".ctl_w"}, {24'd0, rd_W, wb_ctrl_W, we_reg_W}, 32'd0);
    chk({nm, ".pc_w"}, PC_W, 32'd0);
  endtask

  // waits < 0 means the bus never acknowledges.
  task automatic issue(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [1:0] wb, input logic wr, input logic wm,
                       input logic [2:0] ls, input logic [31:0] pc, input int waits,
                       input logic [31:0] rdata, input logic exp_req, input int exp_stalls,
                       input logic exp_err, input logic exp_mis, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_mem,
                       input logic bubble);
    wrec_t e;
    int c;
    int stalls;
    bit done;
    @(negedge clk);
    drive(addr, wdata, rd, wb, wr, wm, ls, pc);
    dbus_rdata = rdata;
    dbus_ack   = 1'b0;
    if (bubble) e = '0;
    else e = '{alu: addr, mem: exp_mem, rd: rd, wb: wb, we: wr, pc: pc};
    q.push_back(e);
    c = 0; stalls = 0; done = 1'b0;
    while (!done) begin
      dbus_ack = (waits >= 0) && (c == waits);
      #1;
      if (c == 0) begin
        chk({nm, ".req"}, {31'd0, dbus_req}, {31'd0, exp_req});
        chk({nm, ".we"}, {31'd0, dbus_we}, {31'd0, wm && exp_req});
        if (exp_req) chk({nm, ".addr"}, dbus_addr, {addr[31:2], 2'b00});
        if (exp_req && wm) begin
          chk({nm, ".be"}, {28'd0, dbus_be}, {28'd0, exp_be});
          chk({nm, ".wdata"}, dbus_wdata, exp_wdata);
        end
      end
      if (!stall_M) begin
        chk({nm, ".bus_err"}, {31'd0, bus_err_M}, {31'd0, exp_err});
        chk({nm, ".misalign"}, {31'd0, misalign_M}, {31'd0, exp_mis});
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 40) begin
          chk({nm, ".stall_bound"}, 32'd1, 32'd0);
          done = 1'b1;
        end else begin
          @(negedge clk);
          c++;
        end
      end
    end
    chk({nm, ".stalls"}, stalls, exp_stalls);
  endtask

  initial begin : monitor
    wrec_t e;
    bit r;
    forever begin
      @(posedge clk);
      r = !rst && !stall_M && (q.size() > 0);
      #1;
      if (r) begin
        e = q.pop_front();
        chk("w.alu", ALU_result_W, e.alu);
        chk("w.mem", mem_data_W, e.mem);
        chk("w.ctl", {24'd0, rd_W, wb_ctrl_W, we_reg_W}, {24'd0, e.rd, e.wb, e.we});
        chk("w.pc", PC_W, e.pc);
      end
    end
  end

  initial begin : stim
    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'd0;
    drive(32'h3000, 32'd0, 5'd1, 2'b01, 1'b1, 1'b0, 3'b010, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst.req", {31'd0, dbus_req}, 32'd0);
    chk("rst.stall", {31'd0, stall_M}, 32'd0);
    chk("rst.err", {30'd0, misalign_M, bus_err_M}, 32'd0);
    check_w_zero("rst");
    drive(32'd0, 32'd0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'd0);
    rst = 1'b0;

    //     name   addr          wdata         rd  wb    wr wm ls      pc     waits rdata         req st err mis be       wdata         mem           bub
    issue("alu",  32'h11223344, 32'h0,        5'd5, 2'b00, 1, 0, 3'b010, 32'h100, 0, 32'h0,        0, 0,  0,  0, 4'b0000, 32'h0,        32'h0,        0);
    issue("lb",   32'h00001003, 32'h0,        5'd6, 2'b01, 1, 0, 3'b000, 32'h104, 0, 32'h80FFFFFF, 1, 0,  0,  0, 4'b0000, 32'h0,        32'hFFFFFF80, 0);
    issue("sh",   32'h00002002, 32'h0000BEEF, 5'd0, 2'b00, 0, 1, 3'b001, 32'h108, 0, 32'h0,        1, 0,  0,  0, 4'b1100, 32'hBEEFBEEF, 32'h0,        0);
    issue("lw3",  32'h00003000, 32'h0,        5'd7, 2'b01, 1, 0, 3'b010, 32'h10C, 3, 32'h12345678, 1, 3,  0,  0, 4'b0000, 32'h0,        32'h12345678, 0);
    issue("lwmis",32'h00003001, 32'h0,        5'd8, 2'b01, 1, 0, 3'b010, 32'h110, 0, 32'h0,        0, 0,  0,  1, 4'b0000, 32'h0,        32'h0,        1);
    issue("sb",   32'h00001001, 32'h000000A5, 5'd0, 2'b00, 0, 1, 3'b000, 32'h114, 1, 32'h0,        1, 1,  0,  0, 4'b0010, 32'hA5A5A5A5, 32'h0,        0);
    issue("lbu",  32'h00001002, 32'h0,        5'd9, 2'b01, 1, 0, 3'b100, 32'h118, 0, 32'h00C30000, 1, 0,  0,  0, 4'b0000, 32'h0,        32'h000000C3, 0);
    issue("lh",   32'h00001002, 32'h0,        5'd10,2'b01, 1, 0, 3'b001, 32'h11C, 2, 32'h80010000, 1, 2,  0,  0, 4'b0000, 32'h0,        32'hFFFF8001, 0);
    issue("lhmis",32'h00001001, 32'h0,        5'd11,2'b01, 1, 0, 3'b001, 32'h120, 0, 32'h0,        0, 0,  0,  1, 4'b0000, 32'h0,        32'h0,        1);
    issue("swmis",32'h00005002, 32'h12345678, 5'd0, 2'b00, 0, 1, 3'b010, 32'h124, 0, 32'h0,        0, 0,  0,  1, 4'b0000, 32'h0,        32'h0,        1);
    issue("ls011",32'h00006000, 32'h0,        5'd12,2'b01, 1, 0, 3'b011, 32'h128, 0, 32'hCAFEF00D, 1, 0,  0,  0, 4'b0000, 32'h0,        32'hCAFEF00D, 0);
    issue("swto", 32'h00007000, 32'hDEADBEEF, 5'd0, 2'b00, 0, 1, 3'b010, 32'h12C, -1, 32'h0,       1, 16, 1,  0, 4'b1111, 32'hDEADBEEF, 32'h0,        1);

    // Reset in the second WAIT cycle of a load, then an LHU straight after release.
    @(negedge clk);
    drive(32'h3000, 32'd0, 5'd3, 2'b01, 1'b1, 1'b0, 3'b010, 32'h200);
    dbus_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rwait.stall_pre", {31'd0, stall_M}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rwait.req", {31'd0, dbus_req}, 32'd0);
    chk("rwait.stall", {31'd0, stall_M}, 32'd0);
    check_w_zero("rwait");
    @(negedge clk);
    drive(32'h4002, 32'd0, 5'd4, 2'b01, 1'b1, 1'b0, 3'b101, 32'h204);
    #1;
    chk("rwait.req_ind", {31'd0, dbus_req}, 32'd0);
    q.push_back('{alu: 32'h4002, mem: 32'h0000F00D, rd: 5'd4, wb: 2'b01, we: 1'b1, pc: 32'h204});
    rst = 1'b0;
    dbus_rdata = 32'hF00D0000;
    dbus_ack = 1'b1;
    #1;
    chk("lhu.req", {31'd0, dbus_req}, 32'd1);
    chk("lhu.stall", {31'd0, stall_M}, 32'd0);
    @(negedge clk);
    dbus_ack = 1'b0;
    drive(32'd0, 32'd0, 5'd0, 2'b00, 1'b0, 1'b0, 3'b000, 32'd0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset; ports are listed below as name, direction, width, meaning.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 ALU_result_M  in  32  ALU result from the EX/ME register; this is the memory address for loads and stores.
REQ-005 write_data_M, rd_M, wb_ctrl_M, we_reg_M, we_mem_M, ls_type_M, PC_M  in  32/5/2/1/1/3/32  remaining EX/ME register outputs.
REQ-006 dbus_req, dbus_we  out  1/1  data bus request and write enable.
REQ-007 dbus_addr  out  32  word address: ALU_result_M with bits [1:0] forced to 0.
REQ-008 dbus_wdata, dbus_be  out  32/4  lane-aligned store data and byte enables.
REQ-009 dbus_rdata, dbus_ack  in  32/1  read data and access-complete strobe; dbus_rdata is valid while dbus_ack=1.
REQ-010 stall_M  out  1  holds upstream stages; the upstream stages keep all *_M inputs stable while stall_M=1.
REQ-011 misalign_M, bus_err_M  out  1/1  single-cycle error flags.
REQ-012 ALU_result_W, mem_data_W, rd_W, wb_ctrl_W, we_reg_W, PC_W  out  32/32/5/2/1/32  registered ME/WB outputs.

Function
REQ-013 Classification: load = (wb_ctrl_M==2'b01 && we_reg_M); store = we_mem_M; mem_op = load || store.
REQ-014 Size encoding of ls_type_M: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; any other value SHALL be treated as word.
REQ-015 Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL be misaligned; misaligned = mem_op && that condition.
REQ-016 A misaligned access SHALL NOT raise dbus_req and SHALL assert misalign_M combinationally for that cycle.
REQ-017 A misaligned access SHALL load a bubble into W: we_reg_W=0, rd_W=0, all other W outputs 0.
REQ-018 FSM states SHALL be IDLE and WAIT; the state register, the 4-bit timeout counter and all W registers SHALL use async reset.
REQ-019 dbus_req SHALL be 1 when in WAIT, or when in IDLE with mem_op && !misaligned.
REQ-020 dbus_we SHALL equal store whenever dbus_req=1.
REQ-021 IDLE transitions: if dbus_req && !dbus_ack, go to WAIT with counter=0; otherwise stay in IDLE.
REQ-022 WAIT transitions: on dbus_ack, go to IDLE; else if counter==15, go to IDLE and assert bus_err_M for one cycle; else increment counter.
REQ-023 stall_M SHALL equal dbus_req && !dbus_ack && !(state==WAIT && counter==15).
REQ-024 Store byte enables: byte → 0001<<addr[1:0]; half → 0011<<addr[1:0]; word → 1111.
REQ-025 Store data: write_data_M[7:0] replicated to 4 lanes for byte; write_data_M[15:0] replicated to 2 lanes for half; write_data_M for word.
REQ-026 Load data: select the addressed byte or half of dbus_rdata and sign-extend (000/001) or zero-extend (100/101) to 32 bits; word loads pass through.
REQ-027 W update when stall_M=1: W SHALL load a bubble.
REQ-028 W update on timeout: W SHALL load a bubble.
REQ-029 W update otherwise: W SHALL load the M inputs; mem_data_W receives the extended load data on a load, else 0.
REQ-030 Latency: a zero-wait access (ack in the request cycle) SHALL reach W at the next edge; N wait cycles SHALL produce N stall cycles.
REQ-031 Non-memory instructions SHALL pass to W in 1 cycle with no stall.

Reset
REQ-032 While rst=1: state=IDLE, counter=0, and all W outputs 0.
REQ-033 dbus_req, stall_M, misalign_M and bus_err_M SHALL be 0 while rst=1, independent of the inputs.
REQ-034 Reset asserted mid-WAIT SHALL abort the access immediately; the first cycle after reset release SHALL start in IDLE.

Verification
REQ-035 LB at addr 0x1003, dbus_rdata=0x80FFFFFF, ack same cycle → no stall; next edge mem_data_W=0xFFFFFF80, we_reg_W=1.
REQ-036 SH at addr 0x2002, write_data_M=0x0000BEEF → dbus_be=1100, dbus_wdata=0xBEEFBEEF, dbus_we=1.
REQ-037 LW at addr 0x3000, ack after 3 wait cycles, rdata=0x12345678 → stall_M high for 3 cycles; then mem_data_W=0x12345678.
REQ-038 LW at addr 0x3001 → dbus_req=0, misalign_M=1 for one cycle, we_reg_W=0 next edge.
REQ-039 Store with ack never asserted → stall_M for 16 cycles, then bus_err_M=1 for one cycle and FSM returns to IDLE.
REQ-040 rst pulsed in the 2nd WAIT cycle → all outputs 0 immediately; after release a new LHU at addr 0x4002 with rdata=0xF00D0000 gives mem_data_W=0x0000F00D.
